// File: rtl/mor1kx_l15_rr_arbiter.sv
// Round-robin arbiter sharing one L1.5 request/response port among
// NUM_REQ L1 transducers. Only one transaction is in flight at a time:
// grant -> issue request -> wait for response -> back to idle.
module mor1kx_l15_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // requester side
  input  logic [NUM_REQ-1:0]      req_val,
  input  logic [5*NUM_REQ-1:0]    req_rqtype,
  input  logic [4*NUM_REQ-1:0]    req_amo_op,
  input  logic [NUM_REQ-1:0]      req_nc,
  input  logic [3*NUM_REQ-1:0]    req_size,
  input  logic [2*NUM_REQ-1:0]    req_l1rplway,
  input  logic [40*NUM_REQ-1:0]   req_address,
  input  logic [64*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_resp_ack,
  output logic [NUM_REQ-1:0]      req_header_ack,
  output logic [NUM_REQ-1:0]      req_resp_val,
  output logic [3:0]              resp_returntype,
  output logic [1:0]              resp_error,
  output logic                    resp_noncacheable,
  output logic [63:0]             resp_data_0,
  output logic [63:0]             resp_data_1,
  output logic [63:0]             resp_data_2,
  output logic [63:0]             resp_data_3,
  // L1.5 side
  input  logic                    l15_header_ack,
  input  logic                    l15_val,
  input  logic [3:0]              l15_returntype,
  input  logic [1:0]              l15_error,
  input  logic                    l15_noncacheable,
  input  logic [63:0]             l15_data_0,
  input  logic [63:0]             l15_data_1,
  input  logic [63:0]             l15_data_2,
  input  logic [63:0]             l15_data_3,
  output logic                    l15_req_val,
  output logic [4:0]              l15_rqtype,
  output logic [3:0]              l15_amo_op,
  output logic                    l15_nc,
  output logic [2:0]              l15_size,
  output logic [1:0]              l15_l1rplway,
  output logic [39:0]             l15_address,
  output logic [63:0]             l15_data,
  output logic                    l15_resp_ack,
  // status
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy,
  output logic                    unexp_resp
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic [CW-1:0]     cand;
  logic [NUM_REQ-1:0] owner_oh;
  logic              owner_ack;
  logic              done;

  // per-requester views of the packed request buses
  logic [NUM_REQ-1:0][4:0]  rqtype_a;
  logic [NUM_REQ-1:0][3:0]  amo_a;
  logic [NUM_REQ-1:0][2:0]  size_a;
  logic [NUM_REQ-1:0][1:0]  rpl_a;
  logic [NUM_REQ-1:0][39:0] addr_a;
  logic [NUM_REQ-1:0][63:0] data_a;

  assign rqtype_a = req_rqtype;
  assign amo_a    = req_amo_op;
  assign size_a   = req_size;
  assign rpl_a    = req_l1rplway;
  assign addr_a   = req_address;
  assign data_a   = req_data;

  // one-hot owner decode; out-of-range grant values never match
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_owner
    assign owner_oh[i] = (grant_idx == IDX_W'(i));
  end

  assign any_req   = |req_val;
  assign owner_ack = |(req_resp_ack & owner_oh);
  assign done      = (state == WAIT_RESP) && l15_val && owner_ack;

  // response payload is a plain broadcast; only the valid is routed
  assign resp_returntype   = l15_returntype;
  assign resp_error        = l15_error;
  assign resp_noncacheable = l15_noncacheable;
  assign resp_data_0       = l15_data_0;
  assign resp_data_1       = l15_data_1;
  assign resp_data_2       = l15_data_2;
  assign resp_data_3       = l15_data_3;

  // round-robin pick: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      // descending k so the closest-to-pointer requester wins last
      if (req_val[cand[IDX_W-1:0]]) pick = cand[IDX_W-1:0];
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; stray responses and header acks never move the FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req)        state_nxt = ISSUE;
      ISSUE:     if (l15_header_ack) state_nxt = WAIT_RESP;
      WAIT_RESP: if (done)           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // grant, round-robin pointer and sticky unexpected-response flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx  <= '0;
      rr_ptr     <= '0;
      unexp_resp <= 1'b0;
    end else begin
      if (state == IDLE && any_req) grant_idx <= pick;
      if (done) rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (l15_val && state != WAIT_RESP) unexp_resp <= 1'b1;
    end
  end

  // outputs: request fields muxed from the owner only while issuing
  always_comb begin
    busy           = (state != IDLE);
    l15_req_val    = 1'b0;
    l15_rqtype     = '0;
    l15_amo_op     = '0;
    l15_nc         = 1'b0;
    l15_size       = '0;
    l15_l1rplway   = '0;
    l15_address    = '0;
    l15_data       = '0;
    req_header_ack = '0;
    req_resp_val   = '0;
    // stray responses are swallowed outside WAIT_RESP, but not under reset
    l15_resp_ack   = l15_val & ~rst;
    case (state)
      ISSUE: begin
        l15_req_val    = 1'b1;
        l15_rqtype     = rqtype_a[grant_idx];
        l15_amo_op     = amo_a[grant_idx];
        l15_nc         = |(req_nc & owner_oh);
        l15_size       = size_a[grant_idx];
        l15_l1rplway   = rpl_a[grant_idx];
        l15_address    = addr_a[grant_idx];
        l15_data       = data_a[grant_idx];
        req_header_ack = l15_header_ack ? owner_oh : '0;
      end
      WAIT_RESP: begin
        req_resp_val = l15_val ? owner_oh : '0;
        l15_resp_ack = owner_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mor1kx_l15_rr_arbiter.sv
// Bench for mor1kx_l15_rr_arbiter with four requesters: a vector table of
// single transactions plus hand-written reset / stray-response sequences.
module tb_mor1kx_l15_rr_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_val;
  logic [5*N-1:0] req_rqtype;
  logic [4*N-1:0] req_amo_op;
  logic [N-1:0]  req_nc;
  logic [3*N-1:0] req_size;
  logic [2*N-1:0] req_l1rplway;
  logic [40*N-1:0] req_address;
  logic [64*N-1:0] req_data;
  logic [N-1:0]  req_resp_ack;
  logic [N-1:0]  req_header_ack, req_resp_val;
  logic [3:0]    resp_returntype;
  logic [1:0]    resp_error;
  logic          resp_noncacheable;
  logic [63:0]   resp_data_0, resp_data_1, resp_data_2, resp_data_3;
  logic          l15_header_ack, l15_val;
  logic [3:0]    l15_returntype;
  logic [1:0]    l15_error;
  logic          l15_noncacheable;
  logic [63:0]   l15_data_0, l15_data_1, l15_data_2, l15_data_3;
  logic          l15_req_val;
  logic [4:0]    l15_rqtype;
  logic [3:0]    l15_amo_op;
  logic          l15_nc;
  logic [2:0]    l15_size;
  logic [1:0]    l15_l1rplway;
  logic [39:0]   l15_address;
  logic [63:0]   l15_data;
  logic          l15_resp_ack;
  logic [1:0]    grant_idx;
  logic          busy, unexp_resp;

  mor1kx_l15_rr_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rqtype(req_rqtype), .req_amo_op(req_amo_op),
    .req_nc(req_nc), .req_size(req_size), .req_l1rplway(req_l1rplway),
    .req_address(req_address), .req_data(req_data), .req_resp_ack(req_resp_ack),
    .req_header_ack(req_header_ack), .req_resp_val(req_resp_val),
    .resp_returntype(resp_returntype), .resp_error(resp_error),
    .resp_noncacheable(resp_noncacheable),
    .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
    .resp_data_2(resp_data_2), .resp_data_3(resp_data_3),
    .l15_header_ack(l15_header_ack), .l15_val(l15_val),
    .l15_returntype(l15_returntype), .l15_error(l15_error),
    .l15_noncacheable(l15_noncacheable),
    .l15_data_0(l15_data_0), .l15_data_1(l15_data_1),
    .l15_data_2(l15_data_2), .l15_data_3(l15_data_3),
    .l15_req_val(l15_req_val), .l15_rqtype(l15_rqtype), .l15_amo_op(l15_amo_op),
    .l15_nc(l15_nc), .l15_size(l15_size), .l15_l1rplway(l15_l1rplway),
    .l15_address(l15_address), .l15_data(l15_data), .l15_resp_ack(l15_resp_ack),
    .grant_idx(grant_idx), .busy(busy), .unexp_resp(unexp_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grant;
    logic [39:0] addr;
    logic [63:0] data;
    logic [4:0]  rqtype;
    logic [3:0]  amo;
    logic        nc;
    logic [2:0]  size;
    logic [1:0]  rpl;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] grant;  // hand-derived from the round-robin pointer history
    int         hold;   // response cycles with the owner not yet acking
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // per-requester field patterns, distinct per requester and per vector
  function automatic logic [39:0] addr_of(input int i, input int v);
    return {8'hA0 + 8'(i), 16'(v), 16'h1000 + 16'(i)};
  endfunction
  function automatic logic [63:0] data_of(input int i, input int v);
    return {32'hD0D0_0000 + 32'(v), 32'h0000_1000 + 32'(i)};
  endfunction

  task automatic set_fields(input int v);
    for (int i = 0; i < N; i++) begin
      req_rqtype[5*i +: 5]   = 5'(i * 3 + v);
      req_amo_op[4*i +: 4]   = 4'(i + 1 + v);
      req_nc[i]              = 1'((i + v) % 2);
      req_size[3*i +: 3]     = 3'(i + 2 * v);
      req_l1rplway[2*i +: 2] = 2'(3 - i);
      req_address[40*i +: 40] = addr_of(i, v);
      req_data[64*i +: 64]    = data_of(i, v);
    end
  endtask

  function automatic exp_t mk_exp(input int g, input int v);
    exp_t e;
    e.grant  = 2'(g);
    e.addr   = addr_of(g, v);
    e.data   = data_of(g, v);
    e.rqtype = 5'(g * 3 + v);
    e.amo    = 4'(g + 1 + v);
    e.nc     = 1'((g + v) % 2);
    e.size   = 3'(g + 2 * v);
    e.rpl    = 2'(3 - g);
    return e;
  endfunction

  // one full transaction; starts and ends just after a rising edge in IDLE
  task automatic run_txn(input logic [3:0] mask, input logic [1:0] g,
                         input int hold, input int v, input bit keep);
    exp_t e;
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << g;
    set_fields(v);
    req_val = mask;
    sb.push_back(mk_exp(g, v));
    @(posedge clk); #1;
    check("req_latency", l15_req_val, 1'b1);
    n = 0;
    while (!l15_req_val && n < 8) begin @(posedge clk); #1; n++; end
    if (!l15_req_val) begin
      check("issue_timeout", l15_req_val, 1'b1);
      void'(sb.pop_front());
      req_val = '0;
      return;
    end
    e = sb.pop_front();
    check("grant_idx", grant_idx, e.grant);
    check("l15_address", l15_address, e.addr);
    check("l15_data", l15_data, e.data);
    check("l15_rqtype", l15_rqtype, e.rqtype);
    check("l15_amo_op", l15_amo_op, e.amo);
    check("l15_nc", l15_nc, e.nc);
    check("l15_size", l15_size, e.size);
    check("l15_l1rplway", l15_l1rplway, e.rpl);
    check("busy_issue", busy, 1'b1);
    l15_header_ack = 1'b1; #1;
    check("header_ack_route", req_header_ack, oh);
    @(posedge clk); #1;
    l15_header_ack = 1'b0;
    if (!keep) req_val = '0;
    #1;
    check("wait_no_req", l15_req_val, 1'b0);
    check("wait_addr_zero", l15_address, 40'd0);
    check("wait_no_hdr_ack", req_header_ack, 4'd0);
    l15_val = 1'b1;
    l15_data_0 = {32'hFEED_0000, 32'(v)};
    req_resp_ack = ~oh;   // only non-owners ack: must not complete
    for (int h = 0; h < hold; h++) begin
      #1;
      check("resp_val_route", req_resp_val, oh);
      check("resp_ack_nonowner", l15_resp_ack, 1'b0);
      check("resp_data_0", resp_data_0, {32'hFEED_0000, 32'(v)});
      @(posedge clk); #1;
      check("busy_held", busy, 1'b1);
    end
    req_resp_ack = oh; #1;
    check("resp_val_final", req_resp_val, oh);
    check("resp_ack_owner", l15_resp_ack, 1'b1);
    @(posedge clk); #1;
    l15_val = 1'b0;
    req_resp_ack = '0;
    #1;
    check("idle_after_resp", busy, 1'b0);
    check("no_resp_val_idle", req_resp_val, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [63:0] r0, r1, r2, r3;
    vecs[0] = '{4'b0010, 2'd1, 0};  // ptr 0 -> grant 1, ptr 2
    vecs[1] = '{4'b0001, 2'd0, 1};  // 2,3,0 -> grant 0, ptr 1
    vecs[2] = '{4'b1111, 2'd1, 3};  // grant 1, ptr 2; 3 stalled cycles
    vecs[3] = '{4'b1111, 2'd2, 0};  // grant 2, ptr 3
    vecs[4] = '{4'b1001, 2'd3, 2};  // grant 3, ptr wraps to 0
    vecs[5] = '{4'b1001, 2'd0, 0};  // grant 0, ptr 1
    vecs[6] = '{4'b0100, 2'd2, 0};  // grant 2, ptr 3
    vecs[7] = '{4'b0011, 2'd0, 1};  // 3,0 -> grant 0, ptr 1

    rst = 1'b1;
    req_val = '0; req_rqtype = '0; req_amo_op = '0; req_nc = '0; req_size = '0;
    req_l1rplway = '0; req_address = '0; req_data = '0; req_resp_ack = '0;
    l15_header_ack = 1'b0; l15_val = 1'b1;  // stray response during reset
    l15_returntype = '0; l15_error = '0; l15_noncacheable = 1'b0;
    l15_data_0 = '0; l15_data_1 = '0; l15_data_2 = '0; l15_data_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_l15_req_val", l15_req_val, 1'b0);
    check("rst_grant_idx", grant_idx, 2'd0);
    check("rst_unexp", unexp_resp, 1'b0);
    check("rst_resp_ack", l15_resp_ack, 1'b0);
    check("rst_hdr_ack", req_header_ack, 4'd0);
    check("rst_resp_val", req_resp_val, 4'd0);
    l15_val = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // broadcast response payload
    r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
    l15_data_0 = r0; l15_data_1 = r1; l15_data_2 = r2; l15_data_3 = r3;
    l15_returntype = 4'hB; l15_error = 2'd2; l15_noncacheable = 1'b1;
    #1;
    check("bcast_d0", resp_data_0, r0);
    check("bcast_d1", resp_data_1, r1);
    check("bcast_d2", resp_data_2, r2);
    check("bcast_d3", resp_data_3, r3);
    check("bcast_type", resp_returntype, 4'hB);
    check("bcast_err", resp_error, 2'd2);
    check("bcast_nc", resp_noncacheable, 1'b1);

    for (int k = 0; k < 8; k++)
      run_txn(vecs[k].mask, vecs[k].grant, vecs[k].hold, k + 1, 1'b0);

    // stray response and stray header ack while idle
    l15_val = 1'b1; #1;
    check("idle_stray_ack", l15_resp_ack, 1'b1);
    check("idle_stray_rv", req_resp_val, 4'd0);
    check("idle_stray_busy", busy, 1'b0);
    @(posedge clk); #1;
    l15_val = 1'b0; #1;
    check("unexp_set", unexp_resp, 1'b1);
    check("idle_busy_after", busy, 1'b0);
    l15_header_ack = 1'b1; #1;
    check("idle_hdr_ignored", req_header_ack, 4'd0);
    @(posedge clk); #1;
    l15_header_ack = 1'b0; #1;
    check("idle_hdr_no_state", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("unexp_sticky", unexp_resp, 1'b1);

    // reset in the middle of WAIT_RESP (ptr is 1 -> grant 1)
    set_fields(30);
    req_val = 4'b0010;
    @(posedge clk); #1;
    check("mid_grant", grant_idx, 2'd1);
    l15_header_ack = 1'b1;
    @(posedge clk); #1;
    l15_header_ack = 1'b0; req_val = '0;
    l15_val = 1'b1; req_resp_ack = 4'b0010; #1;
    check("mid_resp_val", req_resp_val, 4'b0010);
    rst = 1'b1; #1;
    check("async_busy", busy, 1'b0);
    check("async_resp_val", req_resp_val, 4'd0);
    check("async_resp_ack", l15_resp_ack, 1'b0);
    check("async_grant", grant_idx, 2'd0);
    check("async_unexp", unexp_resp, 1'b0);
    l15_val = 1'b0; req_resp_ack = '0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("abandoned_busy", busy, 1'b0);
    check("abandoned_hdr", req_header_ack, 4'd0);

    // all requesters held continuously from a fresh pointer
    for (int k = 0; k < 5; k++)
      run_txn(4'b1111, 2'(k % 4), 0, 40 + k, 1'b1);
    req_val = '0;
    @(posedge clk); #1;

    // requester 2 owns the port while requester 0 toggles (ptr is 1)
    set_fields(50);
    req_val = 4'b0100;
    @(posedge clk); #1;
    check("t_grant", grant_idx, 2'd2);
    check("t_addr", l15_address, addr_of(2, 50));
    for (int k = 0; k < 4; k++) begin
      req_val[0] = ~req_val[0];
      if (k == 1) l15_val = 1'b1;
      #1;
      check("t_hdr0_issue", req_header_ack[0], 1'b0);
      check("t_rv0_issue", req_resp_val[0], 1'b0);
      if (k == 1) check("issue_stray_ack", l15_resp_ack, 1'b1);
      @(posedge clk); #1;
      l15_val = 1'b0;
    end
    #1;
    check("t_still_issue", l15_req_val, 1'b1);
    check("t_grant_kept", grant_idx, 2'd2);
    check("t_unexp_issue", unexp_resp, 1'b1);
    l15_header_ack = 1'b1; req_val[0] = 1'b1; #1;
    check("t_hdr_route", req_header_ack, 4'b0100);
    @(posedge clk); #1;
    l15_header_ack = 1'b0;
    l15_val = 1'b1; req_resp_ack = 4'b0101; req_val[0] = 1'b0; #1;
    check("t_rv_route", req_resp_val, 4'b0100);
    check("t_resp_ack", l15_resp_ack, 1'b1);
    @(posedge clk); #1;
    l15_val = 1'b0; req_resp_ack = '0; req_val = '0; #1;
    check("t_done", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
